// File: rtl/mac_ap_initiator_if.sv
// Handshake bundle between the MAC kernel initiator and its environment:
// upstream operand stream, ap_* kernel control, downstream result stream.
interface mac_ap_initiator_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_a, s_b, s_c, s_d, s_e;

  logic                  k_ap_start;
  logic                  k_ap_ready;
  logic                  k_ap_idle;
  logic                  k_ap_done;
  logic [DATA_WIDTH-1:0] k_a, k_b, k_c, k_d, k_e;
  logic [DATA_WIDTH-1:0] k_result;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_result;

  modport master (
    input  s_valid, s_a, s_b, s_c, s_d, s_e,
    output s_ready,
    output k_ap_start, k_a, k_b, k_c, k_d, k_e,
    input  k_ap_ready, k_ap_idle, k_ap_done, k_result,
    output m_valid, m_result,
    input  m_ready
  );

  modport slave (
    output s_valid, s_a, s_b, s_c, s_d, s_e,
    input  s_ready,
    input  k_ap_start, k_a, k_b, k_c, k_d, k_e,
    output k_ap_ready, k_ap_idle, k_ap_done, k_result,
    input  m_valid, m_result,
    output m_ready
  );
endinterface

// File: rtl/mac_ap_initiator.sv
// Host-side ap_start/ap_done initiator for pipelined MAC kernels: credit-limited
// issue with one-cycle operand skew, result FIFO, timeout and protocol flags.
module mac_ap_initiator #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 5,
  parameter int RES_FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  mac_ap_initiator_if.master  bus,
  input  logic                clear_err,
  output logic [3:0]          outstanding,
  output logic                busy,
  output logic                err_timeout,
  output logic                err_protocol
);
  localparam int AW = $clog2(RES_FIFO_DEPTH);
  localparam int CW = $clog2(RES_FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [DATA_WIDTH-1:0] r_mem [RES_FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic [3:0]            r_outstanding;
  logic                  r_start;
  logic [DATA_WIDTH-1:0] r_pa, r_pb, r_pc, r_pd, r_pe;
  logic [DATA_WIDTH-1:0] r_ka, r_kb, r_kc, r_kd, r_ke;
  logic [TW-1:0]         r_tcnt;
  logic                  r_err_to, r_err_pr;

  logic                  w_done_ok, w_full, w_push, w_pop;
  logic                  w_proto_evt, w_to_rst, w_to_evt;
  logic [4:0]            w_next_out;
  logic [31:0]           w_fifo_use;
  logic                  w_can_issue, w_issue;
  logic                  w_unused_idle;

  assign w_unused_idle = bus.k_ap_idle;

  assign w_done_ok   = bus.k_ap_done && (r_outstanding != '0);
  assign w_full      = (r_count == CW'(RES_FIFO_DEPTH));
  assign w_push      = w_done_ok && !w_full;
  assign w_pop       = (r_count != '0) && bus.m_ready;
  assign w_proto_evt = bus.k_ap_done && ((r_outstanding == '0) || w_full);

  // Credit counts the start pulse already in flight (and the done retiring now);
  // otherwise an accept in the start cycle could push outstanding past the limit.
  assign w_next_out  = {1'b0, r_outstanding} + {4'b0, r_start} - {4'b0, w_done_ok};
  assign w_fifo_use  = 32'(r_outstanding) + 32'(r_start) + 32'(r_count);
  assign w_can_issue = (w_next_out < 5'(MAX_OUTSTANDING)) &&
                       (w_fifo_use < 32'(RES_FIFO_DEPTH));
  assign bus.s_ready = w_can_issue && bus.k_ap_ready;
  assign w_issue     = bus.s_valid && bus.s_ready;

  assign w_to_rst    = bus.k_ap_done || (r_outstanding == '0);
  assign w_to_evt    = !w_to_rst && (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_start       <= 1'b0;
      r_pa <= '0; r_pb <= '0; r_pc <= '0; r_pd <= '0; r_pe <= '0;
      r_ka <= '0; r_kb <= '0; r_kc <= '0; r_kd <= '0; r_ke <= '0;
      r_outstanding <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_tcnt        <= '0;
      r_err_to      <= 1'b0;
      r_err_pr      <= 1'b0;
    end else begin
      r_start <= w_issue;
      if (w_issue) begin
        r_pa <= bus.s_a; r_pb <= bus.s_b; r_pc <= bus.s_c;
        r_pd <= bus.s_d; r_pe <= bus.s_e;
      end
      if (r_start) begin
        r_ka <= r_pa; r_kb <= r_pb; r_kc <= r_pc; r_kd <= r_pd; r_ke <= r_pe;
      end

      case ({r_start, w_done_ok})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase

      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_to_rst)
        r_tcnt <= '0;
      else if (r_tcnt != TW'(TIMEOUT_CYCLES))
        r_tcnt <= r_tcnt + TW'(1);

      r_err_to <= (r_err_to && !clear_err) || w_to_evt;
      r_err_pr <= (r_err_pr && !clear_err) || w_proto_evt;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_push) r_mem[r_wptr] <= bus.k_result;
  end

  assign bus.k_ap_start = r_start;
  assign bus.k_a        = r_ka;
  assign bus.k_b        = r_kb;
  assign bus.k_c        = r_kc;
  assign bus.k_d        = r_kd;
  assign bus.k_e        = r_ke;
  assign bus.m_valid    = (r_count != '0);
  assign bus.m_result   = (r_count != '0) ? r_mem[r_rptr] : '0;

  assign outstanding    = r_outstanding;
  assign busy           = (r_outstanding != '0) || (r_count != '0) || r_start;
  assign err_timeout    = r_err_to;
  assign err_protocol   = r_err_pr;
endmodule
